ball_motion: RTL

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/brick_pkg.sv | 14 +
 rtl/ball_motion.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/brick_pkg.sv
// Shared definitions for the brick game: screen geometry and ball FSM states.
package brick_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_MOVE      = 2'd1,
        ST_LOST      = 2'd2,
        ST_GAME_OVER = 2'd3
    } ball_state_e;

endpackage

// File: rtl/ball_motion.sv
// Ball motion engine: serve tracking, wall/paddle reflection, floor loss,
// lives bookkeeping and game-over. All state advances only on tick_move.
//
// Handshake: there is no valid/ready pair here; tick_move is a one-clock
// strobe and every input is sampled on the clk edge where tick_move=1.
module ball_motion
    import brick_pkg::*;
#(
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 100,
    parameter int PADDLE_Y    = 440,
    parameter int LOST_TICKS  = 60,
    parameter int START_LIVES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_move,
    input  logic [9:0]  paddle_x,
    input  logic        launch_n,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        ball_visible,
    output logic [1:0]  lives,
    output logic        lost_pulse,
    output logic        game_over,
    output ball_state_e dbg_state_o,
    output logic        dbg_dx_left_o,
    output logic        dbg_dy_down_o
);

    localparam int CNT_W = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;

    localparam logic [9:0]       SERVE_X_OFS = 10'((PADDLE_W - BALL_SIZE) / 2);
    localparam logic [9:0]       SERVE_Y     = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]       X_MAX       = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]       Y_FLOOR     = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0]      PAD_Y_W     = 11'(PADDLE_Y);
    localparam logic [10:0]      BALL_W      = 11'(BALL_SIZE);
    localparam logic [10:0]      PAD_W_W     = 11'(PADDLE_W);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(LOST_TICKS - 1);
    localparam logic [1:0]       LIVES_INIT  = 2'(START_LIVES);

    ball_state_e      state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             dx_left_q, dx_left_d;
    logic             dy_down_q, dy_down_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    logic [9:0]       serve_x;
    logic             hit_paddle;
    logic             hit_floor;

    // Serve position and collision tests; 11-bit sums keep edge compares wrap-free
    always_comb begin
        serve_x    = paddle_x + SERVE_X_OFS;
        hit_floor  = dy_down_q && (y_q == Y_FLOOR);
        hit_paddle = dy_down_q
                  && (({1'b0, y_q} + BALL_W) == PAD_Y_W)
                  && (({1'b0, x_q} + BALL_W) > {1'b0, paddle_x})
                  && ({1'b0, x_q} < ({1'b0, paddle_x} + PAD_W_W));
    end

    // Next-state logic: FSM transitions, reflections and motion on each tick
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_left_d = dx_left_q;
        dy_down_d = dy_down_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;

        if (tick_move) begin
            case (state_q)
                ST_SERVE: begin
                    x_d       = serve_x;
                    y_d       = SERVE_Y;
                    dx_left_d = 1'b0;
                    dy_down_d = 1'b0;
                    if (!launch_n) state_d = ST_MOVE;
                end
                ST_MOVE: begin
                    if (hit_floor) begin
                        state_d = ST_LOST;
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        // Both axes reflect independently so corners bounce cleanly
                        if (dx_left_q && (x_q == 10'd0))        dx_left_d = 1'b0;
                        else if (!dx_left_q && (x_q == X_MAX))  dx_left_d = 1'b1;
                        if (!dy_down_q && (y_q == 10'd0))       dy_down_d = 1'b1;
                        else if (hit_paddle)                    dy_down_d = 1'b0;
                        x_d = dx_left_d ? (x_q - 10'd1) : (x_q + 10'd1);
                        y_d = dy_down_d ? (y_q + 10'd1) : (y_q - 10'd1);
                    end
                end
                ST_LOST: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (lives_q != 2'd0) begin
                            state_d   = ST_SERVE;
                            x_d       = serve_x;
                            y_d       = SERVE_Y;
                            dx_left_d = 1'b0;
                            dy_down_d = 1'b0;
                        end else begin
                            state_d = ST_GAME_OVER;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset parks the ball on a paddle assumed at column 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SERVE;
            x_q       <= SERVE_X_OFS;
            y_q       <= SERVE_Y;
            dx_left_q <= 1'b0;
            dy_down_q <= 1'b0;
            lives_q   <= LIVES_INIT;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_left_q <= dx_left_d;
            dy_down_q <= dy_down_d;
            lives_q   <= lives_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign ball_x        = x_q;
    assign ball_y        = y_q;
    assign ball_visible  = (state_q == ST_SERVE) || (state_q == ST_MOVE);
    assign lives         = lives_q;
    assign lost_pulse    = pulse_q;
    assign game_over     = (state_q == ST_GAME_OVER);
    assign dbg_state_o   = state_q;
    assign dbg_dx_left_o = dx_left_q;
    assign dbg_dy_down_o = dy_down_q;

endmodule
